multdiv: RTL

Multi-cycle signed 32-bit multiply/divide unit that sits beside the single-cycle ALU in the execute stage. The ALU completes every op in the same cycle; this block handles the ops it cannot. Multiply uses iterative shift-add and divide uses restoring shift-subtract, both on operand magnitudes, with a final sign-correction cycle. The pipeline starts an op with a one-cycle request pulse and stalls until `data_resultRDY` pulses.

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/multdiv_iter_counter.sv | 20 ++
 rtl/multdiv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
package multdiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Magnitude of a two's complement word; INT_MIN maps to itself, which is
  // still the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: synchronous clear, count enable, last-iteration flag.
module iter_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + 1'b1;
  end

  assign last = (count == CNT_W'(ITERS - 1));

endmodule

// File: rtl/multdiv.sv
// Multi-cycle signed 32-bit multiply (shift-add) / divide (restoring) unit
// working on operand magnitudes with a final sign-correction cycle.
module multdiv
  import multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] data_operandA,
  input  logic [XLEN-1:0] data_operandB,
  input  logic            ctrl_MULT,
  input  logic            ctrl_DIV,
  output logic [XLEN-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY
);

  state_e            state;
  logic              isDiv;
  logic              resNeg;
  logic [XLEN-1:0]   aReg;     // multiplicand, or dividend shifted out MSB-first
  logic [XLEN-1:0]   bReg;     // multiplier shifted out LSB-first, or divisor
  logic [2*XLEN-1:0] acc;      // product, or {remainder, quotient}

  logic              start;
  logic              running;
  logic [CNT_W-1:0]  iterCount;
  logic              iterLast;

  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   remSh;
  logic [XLEN:0]     divDiff;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quoSigned;
  logic              mulOvf;
  logic              divZero;
  logic              divOvf;
  logic [XLEN-1:0]   fixResult;
  logic              fixExc;

  assign start   = (state == IDLE) && (ctrl_MULT || ctrl_DIV);
  assign running = (state == RUN);

  iter_counter uCnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (running),
    .count  (iterCount),
    .last   (iterLast)
  );

  always_comb begin
    mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, aReg};
    remSh   = {acc[2*XLEN-2:XLEN], aReg[XLEN-1]};
    divDiff = {1'b0, remSh} - {1'b0, bReg};
  end

  always_comb begin
    prodSigned = resNeg ? (~acc + 64'd1) : acc;
    quoSigned  = resNeg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    // Product fits in 32 bits only if bits 63..31 are a pure sign extension.
    mulOvf     = !((&prodSigned[2*XLEN-1:XLEN-1]) || !(|prodSigned[2*XLEN-1:XLEN-1]));
    divZero    = (bReg == '0);
    // A positive quotient of magnitude INT_MIN only arises from INT_MIN / -1.
    divOvf     = (acc[XLEN-1:0] == INT_MIN) && !resNeg;
    fixResult  = prodSigned[XLEN-1:0];
    fixExc     = mulOvf;
    if (isDiv) begin
      if (divZero) begin
        fixResult = '0;
        fixExc    = 1'b1;
      end else if (divOvf) begin
        fixResult = INT_MIN;
        fixExc    = 1'b1;
      end else begin
        fixResult = quoSigned;
        fixExc    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      isDiv          <= 1'b0;
      resNeg         <= 1'b0;
      aReg           <= '0;
      bReg           <= '0;
      acc            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            isDiv  <= !ctrl_MULT;
            aReg   <= absVal(data_operandA);
            bReg   <= absVal(data_operandB);
            resNeg <= data_operandA[XLEN-1] ^ data_operandB[XLEN-1];
            acc    <= '0;
          end
        end
        RUN: begin
          if (isDiv) begin
            aReg <= {aReg[XLEN-2:0], 1'b0};
            if (divDiff[XLEN]) acc <= {remSh, acc[XLEN-2:0], 1'b0};
            else               acc <= {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          end else begin
            bReg <= {1'b0, bReg[XLEN-1:1]};
            if (bReg[0]) acc <= {mulSum, acc[XLEN-1:1]};
            else         acc <= {1'b0, acc[2*XLEN-1:1]};
          end
          if (iterLast) state <= FIX;
        end
        FIX: begin
          data_result    <= fixResult;
          data_exception <= fixExc;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
